// File: rtl/ycbcr2rgb.sv
// Full-range BT.601 YCbCr 4:4:4 to 8-bit RGB, fixed 3-stage pipeline with sync/valid alignment.
// Also reports the number of saturated pixels seen in each completed frame.
module ycbcr2rgb #(
  parameter int unsigned CNT_W  = 24,
  parameter bit          RND_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             per_img_vsync,
  input  logic             per_img_herf,
  input  logic             per_img_valid,
  input  logic [7:0]       per_img_Y,
  input  logic [7:0]       per_img_Cb,
  input  logic [7:0]       per_img_Cr,
  output logic             post_img_vsync,
  output logic             post_img_herf,
  output logic             post_img_valid,
  output logic [7:0]       post_img_red,
  output logic [7:0]       post_img_green,
  output logic [7:0]       post_img_blue,
  output logic [CNT_W-1:0] clip_cnt,
  output logic             frame_done
);

  // Sync/valid delay lines, bit 2 is the output stage
  logic [2:0] vs_d, vs_q, hf_d, hf_q, vd_d, vd_q;

  // S1
  logic [7:0]        y1_d, y1_q;
  logic signed [8:0] dcb1_d, dcb1_q, dcr1_d, dcr1_q;

  // S2
  logic [15:0]        y2_d, y2_q;
  logic signed [17:0] pr2_d, pr2_q, pgb2_d, pgb2_q, pgr2_d, pgr2_q, pb2_d, pb2_q;

  // S3
  logic signed [19:0] rnd, sum_r, sum_g, sum_b, y_ext;
  logic signed [11:0] sh_r, sh_g, sh_b;
  logic [7:0]         red_d, red_q, green_d, green_q, blue_d, blue_q;
  logic               clip3_d, clip3_q;

  // Frame statistics
  logic             vs_prev_d, vs_prev_q, armed_d, armed_q, frame_done_d, frame_done_q;
  logic [CNT_W-1:0] run_d, run_q, clip_cnt_d, clip_cnt_q;
  logic             rise, clip_pix;

  function automatic logic [7:0] clamp8(input logic signed [11:0] v);
    logic [7:0] r;
    if (v < 12'sd0)        r = 8'd0;
    else if (v > 12'sd255) r = 8'hff;
    else                   r = v[7:0];
    return r;
  endfunction

  function automatic logic is_sat(input logic signed [11:0] v);
    return (v < 12'sd0) || (v > 12'sd255);
  endfunction

  always_comb begin
    vs_d = {vs_q[1:0], per_img_vsync};
    hf_d = {hf_q[1:0], per_img_herf};
    vd_d = {vd_q[1:0], per_img_valid};

    y1_d   = per_img_Y;
    dcb1_d = $signed({1'b0, per_img_Cb}) - 9'sd128;
    dcr1_d = $signed({1'b0, per_img_Cr}) - 9'sd128;

    y2_d   = {y1_q, 8'h00};
    pr2_d  = 18'(dcr1_q) * 18'sd359;
    pgb2_d = 18'(dcb1_q) * 18'sd88;
    pgr2_d = 18'(dcr1_q) * 18'sd183;
    pb2_d  = 18'(dcb1_q) * 18'sd454;

    rnd   = RND_EN ? 20'sd128 : 20'sd0;
    y_ext = $signed({4'b0000, y2_q});
    sum_r = y_ext + 20'(pr2_q) + rnd;
    sum_g = y_ext - 20'(pgb2_q) - 20'(pgr2_q) + rnd;
    sum_b = y_ext + 20'(pb2_q) + rnd;
    sh_r  = 12'(sum_r >>> 8);
    sh_g  = 12'(sum_g >>> 8);
    sh_b  = 12'(sum_b >>> 8);

    red_d   = clamp8(sh_r);
    green_d = clamp8(sh_g);
    blue_d  = clamp8(sh_b);
    clip3_d = is_sat(sh_r) | is_sat(sh_g) | is_sat(sh_b);
  end

  // A clipped pixel arriving with the vsync rise belongs to the new frame
  always_comb begin
    rise     = vs_q[2] & ~vs_prev_q;
    clip_pix = vd_q[2] & clip3_q;

    vs_prev_d    = vs_q[2];
    frame_done_d = rise;
    armed_d      = armed_q | rise;
    clip_cnt_d   = clip_cnt_q;
    run_d        = run_q;
    if (rise) begin
      clip_cnt_d = armed_q ? run_q : '0;
      run_d      = clip_pix ? CNT_W'(1) : '0;
    end else if (clip_pix && (run_q != {CNT_W{1'b1}})) begin
      run_d = run_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_q         <= '0;
      hf_q         <= '0;
      vd_q         <= '0;
      y1_q         <= '0;
      dcb1_q       <= '0;
      dcr1_q       <= '0;
      y2_q         <= '0;
      pr2_q        <= '0;
      pgb2_q       <= '0;
      pgr2_q       <= '0;
      pb2_q        <= '0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
      clip3_q      <= 1'b0;
      vs_prev_q    <= 1'b0;
      armed_q      <= 1'b0;
      frame_done_q <= 1'b0;
      run_q        <= '0;
      clip_cnt_q   <= '0;
    end else begin
      vs_q         <= vs_d;
      hf_q         <= hf_d;
      vd_q         <= vd_d;
      y1_q         <= y1_d;
      dcb1_q       <= dcb1_d;
      dcr1_q       <= dcr1_d;
      y2_q         <= y2_d;
      pr2_q        <= pr2_d;
      pgb2_q       <= pgb2_d;
      pgr2_q       <= pgr2_d;
      pb2_q        <= pb2_d;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
      clip3_q      <= clip3_d;
      vs_prev_q    <= vs_prev_d;
      armed_q      <= armed_d;
      frame_done_q <= frame_done_d;
      run_q        <= run_d;
      clip_cnt_q   <= clip_cnt_d;
    end
  end

  assign post_img_vsync = vs_q[2];
  assign post_img_herf  = hf_q[2];
  assign post_img_valid = vd_q[2];
  assign post_img_red   = red_q;
  assign post_img_green = green_q;
  assign post_img_blue  = blue_q;
  assign clip_cnt       = clip_cnt_q;
  assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Self-checking bench for ycbcr2rgb: directed colour cases, frame statistics, random sync
// alignment and mid-frame reset, against an arithmetic reference model.
module tb_ycbcr2rgb;

  localparam int unsigned CNT_W = 24;

  typedef struct packed {
    logic       vs;
    logic       hf;
    logic       vd;
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } pix_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             vs = 1'b0, hf = 1'b0, vd = 1'b0;
  logic [7:0]       y = '0, cb = '0, cr = '0;
  logic             post_vs, post_hf, post_vd;
  logic [7:0]       red, green, blue;
  logic [CNT_W-1:0] clip_cnt;
  logic             frame_done;
  logic             t_vs, t_hf, t_vd;
  logic [7:0]       t_red, t_green, t_blue;
  logic [CNT_W-1:0] t_clip_cnt;
  logic             t_frame_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ycbcr2rgb #(.CNT_W(CNT_W), .RND_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .per_img_vsync(vs), .per_img_herf(hf), .per_img_valid(vd),
    .per_img_Y(y), .per_img_Cb(cb), .per_img_Cr(cr),
    .post_img_vsync(post_vs), .post_img_herf(post_hf), .post_img_valid(post_vd),
    .post_img_red(red), .post_img_green(green), .post_img_blue(blue),
    .clip_cnt(clip_cnt), .frame_done(frame_done)
  );

  // Truncating variant, shares the input stream
  ycbcr2rgb #(.CNT_W(CNT_W), .RND_EN(1'b0)) u_dut_trunc (
    .clk(clk), .rst_n(rst_n),
    .per_img_vsync(vs), .per_img_herf(hf), .per_img_valid(vd),
    .per_img_Y(y), .per_img_Cb(cb), .per_img_Cr(cr),
    .post_img_vsync(t_vs), .post_img_herf(t_hf), .post_img_valid(t_vd),
    .post_img_red(t_red), .post_img_green(t_green), .post_img_blue(t_blue),
    .clip_cnt(t_clip_cnt), .frame_done(t_frame_done)
  );

  // ---------------- reference model ----------------
  function automatic int fdiv256(input int a);
    return (a >= 0) ? a / 256 : -((-a + 255) / 256);
  endfunction

  function automatic int clampi(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  function automatic void ref_px(input int yy, input int cbv, input int crv, input bit rnd_on,
                                 output int r, output int g, output int b, output bit clip);
    int k, rr, gg, bb;
    k  = rnd_on ? 128 : 0;
    rr = fdiv256(yy * 256 + 359 * (crv - 128) + k);
    gg = fdiv256(yy * 256 - (88 * (cbv - 128) + 183 * (crv - 128)) + k);
    bb = fdiv256(yy * 256 + 454 * (cbv - 128) + k);
    clip = (rr != clampi(rr)) || (gg != clampi(gg)) || (bb != clampi(bb));
    r = clampi(rr);
    g = clampi(gg);
    b = clampi(bb);
  endfunction

  // hist[2] is the pixel that should be visible at the outputs
  pix_t hist [3];
  int   m_run, m_cnt;
  bit   m_done, m_armed, m_prev_vs;
  int   m_r, m_g, m_b;
  bit   m_c;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) hist[i] <= '0;
      m_run <= 0; m_cnt <= 0; m_done <= 1'b0; m_armed <= 1'b0; m_prev_vs <= 1'b0;
    end else begin
      hist[0] <= '{vs: vs, hf: hf, vd: vd, y: y, cb: cb, cr: cr};
      hist[1] <= hist[0];
      hist[2] <= hist[1];
      ref_px(int'(hist[2].y), int'(hist[2].cb), int'(hist[2].cr), 1'b1, m_r, m_g, m_b, m_c);
      m_prev_vs <= hist[2].vs;
      if (hist[2].vs && !m_prev_vs) begin
        // New frame: report the finished one, current pixel starts the next count
        m_done  <= 1'b1;
        m_cnt   <= m_armed ? m_run : 0;
        m_armed <= 1'b1;
        m_run   <= (hist[2].vd && m_c) ? 1 : 0;
      end else begin
        m_done <= 1'b0;
        if (hist[2].vd && m_c && m_run < (1 << CNT_W) - 1) m_run <= m_run + 1;
      end
    end
  end

  // ---------------- drive helpers (no checking) ----------------
  task automatic apply(input pix_t p);
    vs = p.vs; hf = p.hf; vd = p.vd; y = p.y; cb = p.cb; cr = p.cr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic pix_t mk(input bit v_s, input bit h_f, input bit v_d,
                              input int yy, input int cbv, input int crv);
    pix_t p;
    p.vs = v_s; p.hf = h_f; p.vd = v_d; p.y = 8'(yy); p.cb = 8'(cbv); p.cr = 8'(crv);
    return p;
  endfunction

  function automatic pix_t rnd_pix(input bit v_s, input bit h_f, input bit v_d);
    return mk(v_s, h_f, v_d, $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255));
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    apply(rnd_pix(1'b1, 1'b1, 1'b1));
    tick();
    tick();
    checks++;
    if ({post_vs, post_hf, post_vd, red, green, blue, clip_cnt, frame_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b %b %b %h %h %h %h %b, want all zero",
               post_vs, post_hf, post_vd, red, green, blue, clip_cnt, frame_done);
    end
    checks++;
    if ({t_vs, t_hf, t_vd, t_red, t_green, t_blue, t_clip_cnt, t_frame_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_trunc: got nonzero outputs, want all zero");
    end
    apply('0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_gray();
    int lvl [2];
    lvl[0] = 128;
    lvl[1] = 200;
    for (int i = 0; i < 2; i++) begin
      apply(mk(1'b0, 1'b1, 1'b1, lvl[i], 128, 128));
      tick();
      apply('0);
      tick();
      checks++;
      if (post_vd !== 1'b0) begin
        errors++;
        $display("FAIL gray_latency_early: valid=%b after 2 clk, want 0", post_vd);
      end
      tick();
      checks++;
      if ({post_vd, red, green, blue} !== {1'b1, 8'(lvl[i]), 8'(lvl[i]), 8'(lvl[i])}) begin
        errors++;
        $display("FAIL gray_%0d: valid=%b rgb=(%0d,%0d,%0d), want valid=1 rgb=(%0d,%0d,%0d)",
                 lvl[i], post_vd, red, green, blue, lvl[i], lvl[i], lvl[i]);
      end
      tick();
    end
  endtask

  task automatic test_roundtrip();
    apply(mk(1'b0, 1'b1, 1'b1, 76, 85, 255));
    tick();
    apply('0);
    tick();
    tick();
    checks++;
    if ({post_vd, red, green, blue} !== {1'b1, 8'd254, 8'd0, 8'd0}) begin
      errors++;
      $display("FAIL roundtrip_red: valid=%b rgb=(%0d,%0d,%0d), want valid=1 rgb=(254,0,0)",
               post_vd, red, green, blue);
    end
    tick();
  endtask

  task automatic test_clamp();
    apply(mk(1'b0, 1'b1, 1'b1, 255, 128, 255));
    tick();
    apply(mk(1'b0, 1'b1, 1'b1, 0, 0, 128));
    tick();
    apply('0);
    tick();
    checks++;
    if (red !== 8'd255 || t_red !== 8'd255) begin
      errors++;
      $display("FAIL clamp_high_r: red=%0d trunc_red=%0d, want 255", red, t_red);
    end
    tick();
    checks++;
    if (blue !== 8'd0) begin
      errors++;
      $display("FAIL clamp_low_b: blue=%0d, want 0", blue);
    end
    checks++;
    if (t_blue !== 8'd0) begin
      errors++;
      $display("FAIL clamp_low_b_trunc: blue=%0d, want 0", t_blue);
    end
    tick();
  endtask

  task automatic test_frame_stats();
    pix_t q[$];
    int   got[$];
    int   want [3];
    want[0] = 0; want[1] = 10; want[2] = 1;
    repeat (2) q.push_back(mk(1'b1, 1'b0, 1'b0, 0, 128, 128));
    repeat (2) q.push_back('0);
    repeat (10) q.push_back(mk(1'b0, 1'b1, 1'b1, 255, 128, 255));
    repeat (20) q.push_back(mk(1'b0, 1'b1, 1'b1, $urandom_range(0, 255), 128, 128));
    repeat (3) q.push_back('0);
    q.push_back(mk(1'b1, 1'b0, 1'b1, 255, 128, 255));
    q.push_back(mk(1'b1, 1'b0, 1'b0, 0, 128, 128));
    repeat (3) q.push_back('0);
    repeat (2) q.push_back(mk(1'b1, 1'b0, 1'b0, 0, 128, 128));
    repeat (6) q.push_back('0);
    foreach (q[i]) begin
      apply(q[i]);
      tick();
      checks++;
      if (frame_done !== m_done || clip_cnt !== CNT_W'(m_cnt)) begin
        errors++;
        $display("FAIL frame_stats_cycle%0d: done=%b cnt=%0d, want done=%b cnt=%0d",
                 i, frame_done, clip_cnt, m_done, m_cnt);
      end
      if (frame_done === 1'b1) got.push_back(int'(clip_cnt));
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL frame_stats_pulses: got %0d frame_done pulses, want 3", got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got[k] != want[k]) begin
          errors++;
          $display("FAIL frame_stats_report%0d: clip_cnt=%0d, want %0d", k, got[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_sync_random();
    pix_t q[$];
    int   n_in = 0, n_out = 0, r, g, b;
    bit   c;
    repeat (2) q.push_back(rnd_pix(1'b1, 1'b0, 1'b0));
    repeat (3) q.push_back(rnd_pix(1'b0, 1'b0, 1'b0));
    for (int ln = 0; ln < 4; ln++) begin
      int sent = 0;
      repeat ($urandom_range(1, 4)) q.push_back(rnd_pix(1'b0, 1'b0, 1'b0));
      while (sent < 64) begin
        if ($urandom_range(0, 3) == 0) q.push_back(rnd_pix(1'b0, 1'b1, 1'b0));
        else begin
          q.push_back(rnd_pix(1'b0, 1'b1, 1'b1));
          sent++;
        end
      end
    end
    repeat (2) q.push_back(rnd_pix(1'b0, 1'b0, 1'b0));
    repeat (2) q.push_back(rnd_pix(1'b1, 1'b0, 1'b0));
    repeat (4) q.push_back(rnd_pix(1'b0, 1'b0, 1'b0));
    foreach (q[i]) begin
      apply(q[i]);
      if (q[i].vd) n_in++;
      tick();
      if (post_vd === 1'b1) n_out++;
      checks++;
      if ({post_vs, post_hf, post_vd} !== {hist[2].vs, hist[2].hf, hist[2].vd} ||
          {t_vs, t_hf, t_vd} !== {hist[2].vs, hist[2].hf, hist[2].vd}) begin
        errors++;
        $display("FAIL sync_cycle%0d: vs/hf/vd=%b%b%b, want %b%b%b", i, post_vs, post_hf,
                 post_vd, hist[2].vs, hist[2].hf, hist[2].vd);
      end
      if (hist[2].vd) begin
        ref_px(int'(hist[2].y), int'(hist[2].cb), int'(hist[2].cr), 1'b1, r, g, b, c);
        checks++;
        if ({red, green, blue} !== {8'(r), 8'(g), 8'(b)}) begin
          errors++;
          $display("FAIL rgb_round_cycle%0d: ycbcr=(%0d,%0d,%0d) rgb=(%0d,%0d,%0d), want (%0d,%0d,%0d)",
                   i, hist[2].y, hist[2].cb, hist[2].cr, red, green, blue, r, g, b);
        end
        ref_px(int'(hist[2].y), int'(hist[2].cb), int'(hist[2].cr), 1'b0, r, g, b, c);
        checks++;
        if ({t_red, t_green, t_blue} !== {8'(r), 8'(g), 8'(b)}) begin
          errors++;
          $display("FAIL rgb_trunc_cycle%0d: ycbcr=(%0d,%0d,%0d) rgb=(%0d,%0d,%0d), want (%0d,%0d,%0d)",
                   i, hist[2].y, hist[2].cb, hist[2].cr, t_red, t_green, t_blue, r, g, b);
        end
      end
      checks++;
      if (frame_done !== m_done || clip_cnt !== CNT_W'(m_cnt)) begin
        errors++;
        $display("FAIL stats_cycle%0d: done=%b cnt=%0d, want done=%b cnt=%0d",
                 i, frame_done, clip_cnt, m_done, m_cnt);
      end
    end
    checks++;
    if (n_in != n_out) begin
      errors++;
      $display("FAIL pixel_count: out=%0d, want %0d", n_out, n_in);
    end
  endtask

  task automatic test_reset_mid();
    repeat (5) begin
      apply(rnd_pix(1'b0, 1'b1, 1'b1));
      tick();
    end
    rst_n = 1'b0;
    apply(rnd_pix(1'b0, 1'b1, 1'b1));
    tick();
    checks++;
    if ({post_vs, post_hf, post_vd, red, green, blue, clip_cnt, frame_done} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: vd=%b rgb=(%0d,%0d,%0d) cnt=%0d done=%b, want all zero",
               post_vd, red, green, blue, clip_cnt, frame_done);
    end
    apply(rnd_pix(1'b0, 1'b1, 1'b1));
    tick();
    apply('0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (post_vd !== 1'b0 || t_vd !== 1'b0 || frame_done !== 1'b0 || clip_cnt !== '0) begin
        errors++;
        $display("FAIL reset_mid_stale%0d: vd=%b done=%b cnt=%0d, want 0 0 0",
                 i, post_vd, frame_done, clip_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_gray();
    test_roundtrip();
    test_clamp();
    test_frame_stats();
    test_sync_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
